// File: rtl/trng_debug_fifo_if.sv
// rtl/trng_debug_fifo_if.sv - register API bus for the TRNG debug capture FIFO
interface trng_debug_fifo_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        error;

  modport master (output cs, we, address, write_data, input read_data, error);
  modport slave  (input cs, we, address, write_data, output read_data, error);
endinterface

// File: rtl/trng_debug_fifo.sv
// rtl/trng_debug_fifo.sv - captures CSPRNG words in debug mode into a FIFO drained over the register API
module trng_debug_fifo #(
  parameter int         DEPTH       = 8,
  parameter logic [7:0] ADDR_STATUS = 8'h10,
  parameter logic [7:0] ADDR_DATA   = 8'h11,
  parameter logic [7:0] ADDR_CTRL   = 8'h12,
  parameter logic [7:0] ADDR_DROPS  = 8'h13
) (
  input  logic               clk,
  input  logic               reset_n,
  trng_debug_fifo_if.slave   api,
  input  logic               debug_mode,
  input  logic [31:0]        rnd_data,
  input  logic               rnd_valid,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_drop_cnt;
  logic          r_overflow;
  logic          r_armed;

  logic          w_empty;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_hit_status;
  logic          w_hit_data;
  logic          w_hit_ctrl;
  logic          w_hit_drops;
  logic          w_pop;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_clear;
  logic          w_push_try;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_rd         = api.cs & ~api.we;
  assign w_wr         = api.cs & api.we;
  assign w_hit_status = (api.address == ADDR_STATUS);
  assign w_hit_data   = (api.address == ADDR_DATA);
  assign w_hit_ctrl   = (api.address == ADDR_CTRL);
  assign w_hit_drops  = (api.address == ADDR_DROPS);

  // r_armed swallows the first edge after reset release so a strobe held across it has no effect
  assign w_pop      = r_armed & w_rd & w_hit_data & ~w_empty;
  assign w_ctrl_wr  = r_armed & w_wr & w_hit_ctrl;
  assign w_flush    = w_ctrl_wr & api.write_data[0];
  assign w_clear    = w_ctrl_wr & api.write_data[1];
  assign w_push_try = r_armed & rnd_valid & debug_mode;
  assign w_push     = w_push_try & ~w_flush & (~w_full | w_pop);
  assign w_drop     = w_push_try & ~w_flush & w_full & ~w_pop;

  assign w_status = {16'h0, 8'(r_count), 5'b0, r_overflow, w_full, w_empty};
  assign w_unused = ^api.write_data[31:2];
  assign overflow = r_overflow;

  always_comb begin
    api.read_data = 32'h0;
    api.error     = 1'b0;
    if (w_wr) begin
      api.error = ~w_hit_ctrl;
    end else if (w_rd) begin
      if (w_hit_status) begin
        api.read_data = w_status;
      end else if (w_hit_data) begin
        if (w_empty) api.error = 1'b1;
        else         api.read_data = r_mem[r_rptr];
      end else if (w_hit_drops) begin
        api.read_data = {16'h0, r_drop_cnt};
      end else if (!w_hit_ctrl) begin
        api.error = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
      if (w_clear) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hffff) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rnd_data;
  end

endmodule
